axi_lite_sram_slave: RTL and testbench

//  AXI4-Lite responder for main memory on slave port 0 of the bus fabric (0x0000_0000-0x1FFF_FFFF).

---
 rtl/bus_pkg.sv | 17 +
 rtl/sram_1rw_be.sv | 37 +++
 rtl/axi_lite_sram_slave.sv | 153 +++++++++++++++
 tb/tb_axi_lite_sram_slave.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus fabric definitions: slave FSM state encoding and the address map.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    WR_WAIT,
    WR_RESP
  } slv_state_e;

  localparam logic [31:0] MEM_BASE    = 32'h0000_0000;
  localparam logic [31:0] PERIPH_BASE = 32'h2000_0000;
  localparam int          REGION_MSB  = 31;
  localparam int          REGION_LSB  = 28;

endpackage

// File: rtl/sram_1rw_be.sv
// Single-port synchronous SRAM, 32-bit words, per-byte write enables, 1-cycle read.
// Only the read data register is reset; the array itself keeps whatever it held.
module sram_1rw_be #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-strobed write into the array; disabled bytes keep their old value
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read data register only updates on a read, so it holds between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 32'h0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite responder for main memory: one read or write at a time, served from a
// byte-strobed SRAM after a configurable number of wait states. The SRAM access is
// issued in the cycle before the response becomes valid, so the read data register
// and the committed write line up exactly with rvalid/bvalid.
module axi_lite_sram_slave #(
  parameter int DEPTH_WORDS = 4096,
  parameter int RD_WAIT     = 1,
  parameter int WR_WAIT     = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic        bvalid,
  input  logic        bready
);

  import bus_pkg::slv_state_e;

  localparam int AW = $clog2(DEPTH_WORDS);

  slv_state_e    state, state_d;
  logic [3:0]    cnt, cnt_d;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic          aw_hs, ar_hs, in_idle;
  logic          ram_en, ram_we;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic          unused_addr_bits;

  assign in_idle = (state == bus_pkg::IDLE);
  assign aw_hs   = in_idle & awvalid & wvalid;
  assign ar_hs   = in_idle & arvalid & ~(awvalid & wvalid);
  assign awready = aw_hs;
  assign wready  = aw_hs;
  assign arready = ar_hs;
  assign rvalid  = (state == bus_pkg::RD_RESP);
  assign bvalid  = (state == bus_pkg::WR_RESP);

  assign unused_addr_bits = ^{araddr[31:AW+2], araddr[1:0], awaddr[31:AW+2], awaddr[1:0]};

  // State, wait counter and captured request fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= bus_pkg::IDLE;
      cnt     <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (aw_hs) begin
        idx_q   <= awaddr[AW+1:2];
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end else if (ar_hs) begin
        idx_q <= araddr[AW+1:2];
      end
    end
  end

  // Next state, wait countdown and SRAM port control
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = wstrb_q;
    ram_addr  = idx_q;
    ram_wdata = wdata_q;
    case (state)
      bus_pkg::IDLE: begin
        if (aw_hs) begin
          cnt_d = 4'(WR_WAIT);
          if (WR_WAIT == 0) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_be    = wstrb;
            ram_addr  = awaddr[AW+1:2];
            ram_wdata = wdata;
            state_d   = bus_pkg::WR_RESP;
          end else begin
            state_d = bus_pkg::WR_WAIT;
          end
        end else if (ar_hs) begin
          cnt_d = 4'(RD_WAIT);
          if (RD_WAIT == 0) begin
            ram_en   = 1'b1;
            ram_addr = araddr[AW+1:2];
            state_d  = bus_pkg::RD_RESP;
          end else begin
            state_d = bus_pkg::RD_WAIT;
          end
        end
      end
      bus_pkg::RD_WAIT: begin
        if (cnt <= 4'd1) begin
          ram_en  = 1'b1;
          cnt_d   = 4'd0;
          state_d = bus_pkg::RD_RESP;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      bus_pkg::WR_WAIT: begin
        if (cnt <= 4'd1) begin
          ram_en  = 1'b1;
          ram_we  = 1'b1;
          cnt_d   = 4'd0;
          state_d = bus_pkg::WR_RESP;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      bus_pkg::RD_RESP: begin
        if (rready) state_d = bus_pkg::IDLE;
      end
      bus_pkg::WR_RESP: begin
        if (bready) state_d = bus_pkg::IDLE;
      end
      default: state_d = bus_pkg::IDLE;
    endcase
  end

  sram_1rw_be #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_sram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Self-checking bench for axi_lite_sram_slave. Instance 0 uses the default geometry
// (4096 words, RD_WAIT=1, WR_WAIT=0); instance 1 is a 16-word memory with RD_WAIT=0,
// WR_WAIT=3 for aliasing and mid-write reset. Inputs change and outputs are sampled
// just after the falling clock edge.
module tb_axi_lite_sram_slave;

  localparam int RD_W [2] = '{1, 0};
  localparam int WR_W [2] = '{0, 3};

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] araddr  [2];
  logic        arvalid [2];
  logic        arready [2];
  logic [31:0] rdata   [2];
  logic        rvalid  [2];
  logic        rready  [2];
  logic [31:0] awaddr  [2];
  logic        awvalid [2];
  logic        awready [2];
  logic [31:0] wdata   [2];
  logic [3:0]  wstrb   [2];
  logic        wvalid  [2];
  logic        wready  [2];
  logic        bvalid  [2];
  logic        bready  [2];

  int checks = 0;
  int errors = 0;
  vec_t vecs [12];

  always #5 clk = ~clk;

  axi_lite_sram_slave #(.DEPTH_WORDS(4096), .RD_WAIT(1), .WR_WAIT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
    .rdata(rdata[0]), .rvalid(rvalid[0]), .rready(rready[0]),
    .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
    .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wready(wready[0]),
    .bvalid(bvalid[0]), .bready(bready[0])
  );

  axi_lite_sram_slave #(.DEPTH_WORDS(16), .RD_WAIT(0), .WR_WAIT(3)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
    .rdata(rdata[1]), .rvalid(rvalid[1]), .rready(rready[1]),
    .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
    .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wready(wready[1]),
    .bvalid(bvalid[1]), .bready(bready[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic doWrite(input int u, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    @(negedge clk);
    awaddr[u] = addr; wdata[u] = data; wstrb[u] = strb;
    awvalid[u] = 1'b1; wvalid[u] = 1'b1; bready[u] = 1'b1;
    #1;
    checkOutput("awready_hs", 32'(awready[u]), 32'd1);
    checkOutput("wready_hs", 32'(wready[u]), 32'd1);
    @(negedge clk);
    awvalid[u] = 1'b0; wvalid[u] = 1'b0;
    #1;
    for (int k = 0; k <= WR_W[u]; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      checkOutput($sformatf("bvalid_t%0d", k + 1), 32'(bvalid[u]), 32'(k == WR_W[u]));
    end
    @(negedge clk);
    #1;
    checkOutput("bvalid_clear", 32'(bvalid[u]), 32'd0);
  endtask

  task automatic doRead(input int u, input logic [31:0] addr, input logic [31:0] exp_data);
    @(negedge clk);
    araddr[u] = addr; arvalid[u] = 1'b1; rready[u] = 1'b1;
    #1;
    checkOutput("arready_hs", 32'(arready[u]), 32'd1);
    @(negedge clk);
    arvalid[u] = 1'b0;
    #1;
    for (int k = 0; k <= RD_W[u]; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      checkOutput($sformatf("rvalid_t%0d", k + 1), 32'(rvalid[u]), 32'(k == RD_W[u]));
    end
    checkOutput($sformatf("rdata_%08h", addr), rdata[u], exp_data);
    @(negedge clk);
    #1;
    checkOutput("rvalid_clear", 32'(rvalid[u]), 32'd0);
  endtask

  task automatic applyStimulus(input int u, input vec_t v);
    if (v.is_write) doWrite(u, v.addr, v.data, v.strb);
    else            doRead(u, v.addr, v.exp_rdata);
  endtask

  // Bench watchdog so a stuck run still ends with a report
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'b0101, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'hFF22_FF44};
    vecs[5]  = '{1'b1, 32'h0000_0024, 32'hCAFE_F00D, 4'hF, 32'h0};
    vecs[6]  = '{1'b1, 32'h0000_0024, 32'h1234_5678, 4'h0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 32'hCAFE_F00D};
    vecs[8]  = '{1'b1, 32'h0000_0030, 32'h0000_0000, 4'hF, 32'h0};
    vecs[9]  = '{1'b1, 32'h0000_0031, 32'hAABB_CCDD, 4'b1010, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_0032, 32'h0,         4'h0, 32'hAA00_CC00};
    vecs[11] = '{1'b0, 32'h0000_4010, 32'h0,         4'h0, 32'hDEAD_BEEF};

    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      araddr[u] = 32'h0; arvalid[u] = 1'b0; rready[u] = 1'b0;
      awaddr[u] = 32'h0; awvalid[u] = 1'b0; wdata[u] = 32'h0;
      wstrb[u] = 4'h0; wvalid[u] = 1'b0; bready[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      checkOutput($sformatf("reset_rvalid%0d", u), 32'(rvalid[u]), 32'd0);
      checkOutput($sformatf("reset_bvalid%0d", u), 32'(bvalid[u]), 32'd0);
      checkOutput($sformatf("reset_rdata%0d", u), rdata[u], 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 12; i++) applyStimulus(0, vecs[i]);

    $display("[TB] held write request with bready low");
    @(negedge clk);
    awaddr[0] = 32'h50; wdata[0] = 32'h0BAD_F00D; wstrb[0] = 4'hF;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; bready[0] = 1'b0;
    #1;
    checkOutput("held_awready_hs", 32'(awready[0]), 32'd1);
    @(negedge clk);
    wdata[0] = 32'h1111_1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      checkOutput("held_bvalid", 32'(bvalid[0]), 32'd1);
      checkOutput("held_awready", 32'(awready[0]), 32'd0);
    end
    @(negedge clk);
    bready[0] = 1'b1;
    #1;
    checkOutput("held_bvalid_last", 32'(bvalid[0]), 32'd1);
    @(negedge clk);
    awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    #1;
    checkOutput("held_bvalid_clear", 32'(bvalid[0]), 32'd0);
    doRead(0, 32'h50, 32'h0BAD_F00D);

    $display("[TB] simultaneous read and write request");
    @(negedge clk);
    araddr[0] = 32'h60; arvalid[0] = 1'b1; rready[0] = 1'b1;
    awaddr[0] = 32'h60; wdata[0] = 32'h600D_600D; wstrb[0] = 4'hF;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; bready[0] = 1'b1;
    #1;
    checkOutput("sim_arready_blocked", 32'(arready[0]), 32'd0);
    checkOutput("sim_awready", 32'(awready[0]), 32'd1);
    @(negedge clk);
    awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    #1;
    checkOutput("sim_bvalid", 32'(bvalid[0]), 32'd1);
    checkOutput("sim_arready_in_b", 32'(arready[0]), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("sim_bvalid_clear", 32'(bvalid[0]), 32'd0);
    checkOutput("sim_arready_idle", 32'(arready[0]), 32'd1);
    @(negedge clk);
    arvalid[0] = 1'b0;
    #1;
    checkOutput("sim_rvalid_wait", 32'(rvalid[0]), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("sim_rvalid", 32'(rvalid[0]), 32'd1);
    checkOutput("sim_rdata", rdata[0], 32'h600D_600D);
    @(negedge clk);
    #1;
    checkOutput("sim_rvalid_clear", 32'(rvalid[0]), 32'd0);

    $display("[TB] read backpressure");
    @(negedge clk);
    araddr[0] = 32'h10; arvalid[0] = 1'b1; rready[0] = 1'b0;
    #1;
    checkOutput("bp_arready", 32'(arready[0]), 32'd1);
    @(negedge clk);
    arvalid[0] = 1'b0;
    #1;
    checkOutput("bp_rvalid_wait", 32'(rvalid[0]), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      checkOutput("bp_rvalid_held", 32'(rvalid[0]), 32'd1);
      checkOutput("bp_rdata_held", rdata[0], 32'hDEAD_BEEF);
    end
    @(negedge clk);
    rready[0] = 1'b1;
    #1;
    checkOutput("bp_rvalid_accept", 32'(rvalid[0]), 32'd1);
    @(negedge clk);
    rready[0] = 1'b0;
    #1;
    checkOutput("bp_rvalid_clear", 32'(rvalid[0]), 32'd0);

    $display("[TB] small memory: aliasing");
    doWrite(1, 32'h40, 32'hA5A5_A5A5, 4'hF);
    doRead(1, 32'h00, 32'hA5A5_A5A5);

    $display("[TB] small memory: reset during write wait");
    @(negedge clk);
    awaddr[1] = 32'h00; wdata[1] = 32'h1234_5678; wstrb[1] = 4'hF;
    awvalid[1] = 1'b1; wvalid[1] = 1'b1; bready[1] = 1'b1;
    #1;
    checkOutput("rst_awready_hs", 32'(awready[1]), 32'd1);
    @(negedge clk);
    awvalid[1] = 1'b0; wvalid[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_bvalid_low", 32'(bvalid[1]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      checkOutput("rst_no_bvalid", 32'(bvalid[1]), 32'd0);
    end
    doRead(1, 32'h00, 32'hA5A5_A5A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
